load_store_align: RTL

//  Multicycle load/store alignment unit between datapath and memory. Replaces the fixed size mux.

---
 rtl/lsu_pkg.sv | 54 +++++
 rtl/load_store_align_if.sv | 29 ++
 rtl/lsu_lane_extract.sv | 58 +++++
 rtl/load_store_align.sv | 124 ++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store alignment unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_SW  = 3'b011,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101,
        OP_SB  = 3'b110,
        OP_SH  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_e;

    localparam int CNT_W = 3;

    function automatic logic is_load(op_e op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_unsigned(op_e op);
        return op inside {OP_LBU, OP_LHU};
    endfunction

    function automatic int size_bytes(op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            default:              return 4;
        endcase
    endfunction

    // Maps a byte's memory-order index to the bit lane that holds it.
    function automatic int lane_idx(int k, int lanes, logic big_endian);
        return big_endian ? (lanes - 1 - k) : k;
    endfunction

    function automatic logic is_misaligned(op_e op, logic [1:0] lo);
        case (size_bytes(op))
            2:       return lo[0];
            4:       return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_align_if.sv
// Request/response and memory-side signals of the load/store alignment unit.
interface load_store_align_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic              start;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic              misalign_exc;

    modport slave (
        input  start, op, addr, wdata, mem_rdata,
        output mem_addr, mem_re, mem_we, mem_wdata, rdata, busy, done, misalign_exc
    );

    modport master (
        output start, op, addr, wdata, mem_rdata,
        input  mem_addr, mem_re, mem_we, mem_wdata, rdata, busy, done, misalign_exc
    );
endinterface

// File: rtl/lsu_lane_extract.sv
// Combinational byte/half/word extraction with extension, and store-data merge
// into the addressed lanes of a memory word.
module lsu_lane_extract
    import lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  op_e                         op_i,
    input  logic [$clog2(DATA_W/8)-1:0] ofs_i,
    input  logic [DATA_W-1:0]           word_i,
    input  logic [DATA_W-1:0]           wdata_i,
    output logic [DATA_W-1:0]           ext_o,
    output logic [DATA_W-1:0]           merged_o
);
    localparam int LANES = DATA_W / 8;
    localparam int OFS_W = $clog2(LANES);

    logic [LANES-1:0][7:0] word_b;
    logic [LANES-1:0][7:0] merged_b;
    logic [3:0][7:0]       src_b;
    logic [3:0][7:0]       raw_b;
    logic [OFS_W-1:0]      lane;
    logic [OFS_W-1:0]      phys;
    logic [DATA_W-1:0]     mask;
    logic                  sgn;
    int                    nb;

    assign word_b = word_i;
    assign src_b  = wdata_i[31:0];

    // Result byte j is the j-th least significant byte of the access, so in
    // big-endian mode it comes from the highest address of the access.
    always_comb begin
        nb       = size_bytes(op_i);
        raw_b    = '0;
        merged_b = word_b;
        lane     = '0;
        phys     = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < nb) begin
                lane = BIG_ENDIAN ? OFS_W'(int'(ofs_i) + nb - 1 - j) : OFS_W'(int'(ofs_i) + j);
                phys = OFS_W'(lane_idx(int'(lane), LANES, BIG_ENDIAN));
                raw_b[2'(j)]   = word_b[phys];
                merged_b[phys] = src_b[2'(j)];
            end
        end
        case (nb)
            1:       begin mask = DATA_W'(32'h0000_00FF); sgn = raw_b[0][7]; end
            2:       begin mask = DATA_W'(32'h0000_FFFF); sgn = raw_b[1][7]; end
            default: begin mask = DATA_W'(32'hFFFF_FFFF); sgn = raw_b[3][7]; end
        endcase
        sgn      = sgn & ~is_unsigned(op_i);
        ext_o    = DATA_W'(raw_b) | ({DATA_W{sgn}} & ~mask);
        merged_o = merged_b;
    end

endmodule

// File: rtl/load_store_align.sv
// Multicycle load/store alignment unit: request latch, sequencing FSM,
// memory wait counter and result/write-buffer registers.
module load_store_align
    import lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input logic              clk,
    input logic              reset,
    load_store_align_if.slave bus
);
    localparam int LANES = DATA_W / 8;
    localparam int OFS_W = $clog2(LANES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] wbuf_q, wbuf_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              exc_q, exc_d;
    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] merged;
    op_e               op_in;

    assign op_in = op_e'(bus.op);

    lsu_lane_extract #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .op_i     (op_q),
        .ofs_i    (addr_q[OFS_W-1:0]),
        .word_i   (bus.mem_rdata),
        .wdata_i  (wdata_q),
        .ext_o    (ext),
        .merged_o (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_LB;
            addr_q  <= '0;
            wdata_q <= '0;
            wbuf_q  <= '0;
            rdata_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wbuf_q  <= wbuf_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wbuf_d  = wbuf_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = op_in;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    exc_d   = is_misaligned(op_in, bus.addr[1:0]);
                    if (is_misaligned(op_in, bus.addr[1:0])) begin
                        state_d = S_DONE;
                    end else if (op_in == OP_SW && DATA_W == 32) begin
                        // Full-word store: nothing to preserve, skip the read.
                        wbuf_d  = bus.wdata;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                cnt_d   = CNT_W'(MEM_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (is_load(op_q)) begin
                        rdata_d = ext;
                        state_d = S_DONE;
                    end else begin
                        wbuf_d  = merged;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mem_addr     = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    assign bus.mem_re       = (state_q == S_READ);
    assign bus.mem_we       = (state_q == S_WRITE);
    assign bus.mem_wdata    = wbuf_q;
    assign bus.rdata        = rdata_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.misalign_exc = (state_q == S_DONE) && exc_q;

endmodule
